parity_frame_arbiter: RTL and testbench

- Shares one serial parity engine between two requesters (port 0 and port 1).
- Each requester presents a WIDTH-bit word. The arbiter grants one port round-robin, captures its word, and shifts it MSB-first through an internal 2-state parity tracker (EVEN/ODD).
- It then reports the parity and the id of the served port.
- It sits between word-level producers and the bit-serial parity datapath. The serial bit stream is exported so the shared Mealy parity unit can be fed and cross-checked.

---
 rtl/parity_frame_arbiter.sv | 121 ++++++++++++
 tb/tb_parity_frame_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_arbiter.sv
// rtl/parity_frame_arbiter.sv - round-robin arbiter sharing one serial parity engine between two ports
module parity_frame_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_x,
    output logic             parity_valid,
    output logic             parity_out,
    output logic             result_id
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_acc;
    logic             r_cur_id;
    logic             r_last_id;
    logic             r_ack0;
    logic             r_ack1;
    logic             w_grant;
    logic             w_grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // On a tie the port that was not served last wins.
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_grant    = 1'b1;
                    w_grant_id = ~r_last_id;
                    w_next     = ST_SHIFT;
                end else if (req0) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b0;
                    w_next     = ST_SHIFT;
                end else if (req1) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b1;
                    w_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_acc     <= 1'b0;
            r_cur_id  <= 1'b0;
            r_last_id <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_ack0 <= w_grant && !w_grant_id;
            r_ack1 <= w_grant && w_grant_id;
            if (w_grant) begin
                r_shreg  <= w_grant_id ? data1 : data0;
                r_cur_id <= w_grant_id;
                r_cnt    <= '0;
                r_acc    <= 1'b0;
            end else if (r_state == ST_SHIFT) begin
                r_acc   <= r_acc ^ r_shreg[WIDTH-1];
                r_shreg <= r_shreg << 1;
                r_cnt   <= r_cnt + 1'b1;
            end else if (r_state == ST_DONE) begin
                r_last_id <= r_cur_id;
            end
        end
    end

    assign ack0         = r_ack0;
    assign ack1         = r_ack1;
    assign busy         = (r_state != ST_IDLE);
    assign ser_valid    = (r_state == ST_SHIFT);
    assign ser_x        = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
    assign parity_valid = (r_state == ST_DONE);
    assign parity_out   = (r_state == ST_DONE) && r_acc;
    assign result_id    = (r_state == ST_DONE) && r_cur_id;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
// tb/tb_parity_frame_arbiter.sv - directed self-checking bench for parity_frame_arbiter
module tb_parity_frame_arbiter;

    logic       clk;
    logic       reset;
    logic       req0;
    logic [7:0] data0;
    logic       req1;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       busy;
    logic       ser_valid;
    logic       ser_x;
    logic       parity_valid;
    logic       parity_out;
    logic       result_id;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    parity_frame_arbiter #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .data0        (data0),
        .req1         (req1),
        .data1        (data1),
        .ack0         (ack0),
        .ack1         (ack1),
        .busy         (busy),
        .ser_valid    (ser_valid),
        .ser_x        (ser_x),
        .parity_valid (parity_valid),
        .parity_out   (parity_out),
        .result_id    (result_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic serve_one(input bit id, input logic [7:0] d, input bit exp_p);
        @(negedge clk);
        if (id) begin
            req1  = 1'b1;
            data1 = d;
        end else begin
            req0  = 1'b1;
            data0 = d;
        end
        @(negedge clk);
        check("ack_pulse", {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
        check("busy_on", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("ser_bit", {30'd0, ser_valid, ser_x}, {30'd0, 1'b1, d[7-i]});
            if (i == 1) check("ack_drop", {30'd0, ack1, ack0}, 32'd0);
        end
        @(negedge clk);
        check("result", {29'd0, parity_valid, parity_out, result_id}, {29'd0, 1'b1, exp_p, id});
        @(negedge clk);
        check("idle_after", {28'd0, busy, parity_valid, ack0, ack1}, 32'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int nres;
        bit seen0;
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_outs", {24'd0, ack0, ack1, busy, ser_valid, ser_x, parity_valid, parity_out, result_id}, 32'd0);

        // Single-port frames with hand-computed parities.
        serve_one(1'b0, 8'hA5, 1'b0);
        serve_one(1'b1, 8'h07, 1'b1);
        serve_one(1'b0, 8'h00, 1'b0);
        serve_one(1'b1, 8'hFF, 1'b0);

        // Simultaneous requests straight after reset: port 0 first.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b1;
        data0 = 8'h01;
        req1  = 1'b1;
        data1 = 8'h03;
        @(negedge clk);
        check("tie_ack0", {30'd0, ack1, ack0}, 32'd1);
        t0   = cyc;
        req0 = 1'b0;
        repeat (8) @(negedge clk);
        check("tie_res0", {29'd0, parity_valid, parity_out, result_id}, 32'b110);
        t1 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack1) begin
                t1 = cyc;
                break;
            end
        end
        check("tie_period", t1 - t0, 32'd10);
        req1 = 1'b0;
        repeat (8) @(negedge clk);
        check("tie_res1", {29'd0, parity_valid, parity_out, result_id}, 32'b101);

        // Continuous requests on both ports alternate strictly.
        @(negedge clk);
        @(negedge clk);
        req0  = 1'b1;
        data0 = 8'h55;
        req1  = 1'b1;
        data1 = 8'h0F;
        nres  = 0;
        for (int k = 0; k < 80 && nres < 6; k++) begin
            @(negedge clk);
            check("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
            if (parity_valid) begin
                check("rr_id", {31'd0, result_id}, nres % 2);
                check("rr_par", {31'd0, parity_out}, 32'd0);
                nres++;
                if (nres == 6) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check("rr_count", nres, 32'd6);
        @(negedge clk);
        check("rr_idle", {31'd0, busy}, 32'd0);

        // Reset in the fourth shift cycle aborts the frame.
        req0  = 1'b1;
        data0 = 8'hFF;
        @(negedge clk);
        check("abort_ack", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("abort_outs", {24'd0, ack0, ack1, busy, ser_valid, ser_x, parity_valid, parity_out, result_id}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_no_pv", {30'd0, parity_valid, busy}, 32'd0);
        end
        req0  = 1'b1;
        data0 = 8'h03;
        req1  = 1'b1;
        data1 = 8'h01;
        @(negedge clk);
        check("post_reset_tie", {30'd0, ack1, ack0}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) @(negedge clk);
        check("post_reset_res", {29'd0, parity_valid, parity_out, result_id}, 32'b100);

        // A request arriving mid-frame waits for the next IDLE edge.
        @(negedge clk);
        req0  = 1'b1;
        data0 = 8'h80;
        @(negedge clk);
        check("late_ack0", {31'd0, ack0}, 32'd1);
        t0   = cyc;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        req1  = 1'b1;
        data1 = 8'hC0;
        t1    = -1;
        seen0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (parity_valid && !seen0) begin
                check("late_res0", {30'd0, parity_out, result_id}, 32'b10);
                seen0 = 1'b1;
            end
            if (ack1) begin
                t1 = cyc;
                break;
            end
        end
        check("late_period", t1 - t0, 32'd10);
        req1 = 1'b0;
        repeat (8) @(negedge clk);
        check("late_res1", {29'd0, parity_valid, parity_out, result_id}, 32'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
